dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder sitting on the far side of the core's load/store port. It accepts one request at a time over a valid/ready handshake and models a configurable number of wait states. It performs RISC-V byte, half and word loads and stores with lane alignment and load extension. It returns read data or an error over a second valid/ready handshake, replacing the zero-latency data memory once the core moves to a handshaked bus.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth is 2^ADDR_WIDTH words (4 KiB by default).
- `WAIT_CYCLES`, default 2: wait states between request accept and response; 0 is legal.
- `MEM_INIT`, default "": hex file loaded at elaboration; empty means the array powers up as zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_addr` in 32: byte address.
- `req_we` in 1: 1 = store, 0 = load.
- `req_func3` in 3: RISC-V funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester takes the response.
- `rsp_rdata` out 32: load result, extended. 0 for stores and errors.
- `rsp_err` out 1: request rejected.

## Operation
- FSM states: IDLE, BUSY, RESP. `req_ready` = (state == IDLE); `rsp_valid` = (state == RESP).
- **IDLE:**
  - On `req_valid && req_ready`, latch addr, we, func3 and wdata.
  - Go to BUSY with the counter at WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES == 0.
- **BUSY:** decrement the counter each cycle. On the edge where the counter is 0, go to RESP.
- **Entry to RESP:** the same edge evaluates the request.
  - Error if any of these hold:
    - H/HU with addr[0] set;
    - W with addr[1:0] != 0;
    - func3 in {011, 110, 111};
    - store with func3 in {100, 101};
    - addr[31:ADDR_WIDTH+2] != 0.
  - On error: `rsp_err` = 1, `rsp_rdata` = 0, no array write.
  - Store: on that edge, write only the byte lanes selected by addr[1:0] and the size. `rsp_rdata` = 0.
  - Load: read word addr[ADDR_WIDTH+1:2], shift by addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU). Register the result into `rsp_rdata`.
- **RESP:** hold `rsp_rdata` and `rsp_err` stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Only one transaction is outstanding at a time. A `req_valid` outside IDLE is ignored, not queued.

## Timing
- Reset values:
  - state IDLE, so `req_ready` = 1 during and after reset;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter 0.
  - Array contents are not reset.
- Accept on edge t → `rsp_valid` high after edge t+WAIT_CYCLES (after edge t itself when WAIT_CYCLES = 0).
- The store commits on that same edge.
- Response taken on edge r → `req_ready` high after edge r. The next accept is at the earliest on edge r+1.
- Throughput with `rsp_ready` tied high: one transaction per WAIT_CYCLES+2 cycles.
- Reset asserted mid-transaction, in any state:
  - return to IDLE immediately and drop the outstanding request;
  - a store not yet committed is lost;
  - committed stores persist.
- Latched request fields are unaffected by input changes after accept.

## Structure
- Package `dmem_pkg` holds:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the `dmem_state_t` enum (IDLE, BUSY, RESP).
- Sub-module `mem_lane_align` (combinational) provides:
  - load extraction and extension: word, offset, func3 → rdata;
  - store merge: old word, wdata, offset, func3 → new word plus 4-bit byte-enable;
  - the misalignment flag.
- The top level holds the FSM, counter, request latch, array and range check.

## Test plan
1. **Word store/load:** reset, WAIT_CYCLES=2. SW 0xDEADBEEF @0x10, then LW @0x10 → `rsp_valid` exactly 2 edges after each accept, `rdata`=0xDEADBEEF, `err`=0.
2. **Sub-word access:** continuing from 1, SB 0x80 @0x13, then:
   - LB @0x13 → 0xFFFFFF80;
   - LBU @0x13 → 0x00000080;
   - LW @0x10 → 0x80ADBEEF;
   - LH @0x12 → 0xFFFF80AD.
3. **Misaligned and out-of-range:** SH @0x11 → `err`=1 and memory unchanged (LW @0x10 still 0x80ADBEEF). LW @0x1000 with ADDR_WIDTH=10 → `err`=1, `rdata`=0.
4. **Backpressure:** `rsp_ready` low 5 cycles on a load → `rsp_valid`/`rdata` stable, `req_ready`=0, and a concurrent `req_valid` is never accepted.
5. **Reset during BUSY:** assert `rst_n`=0 while SW 0x12345678 @0x20 is in BUSY → `req_ready`=1 and `rsp_valid`=0 immediately. After release, LW @0x20 → 0x00000000.
6. **Zero wait states:** WAIT_CYCLES=0, back-to-back LWs with `rsp_ready`=1 → `rsp_valid` the cycle after each accept, one transaction per 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RISC-V load/store funct3 encodings used to size and extend accesses
//   - dmem_state_t: responder FSM states
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response handshakes.
//   master : the core side (drives requests, accepts responses)
//   slave  : the responder side
interface dmem_responder_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_func3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_func3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// mem_lane_align: combinational byte-lane steering for RISC-V loads/stores.
//   word_i       : current memory word at the addressed location
//   wdata_i      : right-aligned store data
//   offset_i     : byte offset within the word (addr[1:0])
//   func3_i      : access size / extension
//   rdata_o      : extracted and sign/zero-extended load data
//   new_word_o   : word with store data merged into the selected lanes
//   be_o         : byte enables of the store lanes
//   misaligned_o : access crosses its natural alignment
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] rdata_o,
  output logic [31:0] new_word_o,
  output logic [3:0]  be_o,
  output logic        misaligned_o
);

  logic [31:0] shifted_s;
  logic [31:0] wrep_s;
  logic [3:0]  be_base_s;

  // Load path: move the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted_s = word_i >> {offset_i, 3'b000};
    case (func3_i)
      F3_B:    rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {24'd0, shifted_s[7:0]};
      F3_HU:   rdata_o = {16'd0, shifted_s[15:0]};
      default: rdata_o = 32'd0;
    endcase
  end

  // Store path: replicate data across lanes so any offset finds it in place.
  always_comb begin
    case (func3_i)
      F3_B: begin
        be_base_s = 4'b0001;
        wrep_s    = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_base_s = 4'b0011;
        wrep_s    = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_base_s = 4'b1111;
        wrep_s    = wdata_i;
      end
      default: begin
        be_base_s = 4'b0000;
        wrep_s    = 32'd0;
      end
    endcase
    be_o = be_base_s << offset_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) begin
        new_word_o[8*i +: 8] = wrep_s[8*i +: 8];
      end else begin
        new_word_o[8*i +: 8] = word_i[8*i +: 8];
      end
    end
  end

  // Natural-alignment check for halfword and word accesses.
  always_comb begin
    case (func3_i)
      F3_H, F3_HU: misaligned_o = offset_i[0];
      F3_W:        misaligned_o = (offset_i != 2'b00);
      default:     misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states.
//   clk, rst_n : clock (rising edge) and async active-low reset
//   dmem       : slave side of dmem_responder_if (request + response handshakes)
// Parameters: ADDR_WIDTH word-address bits, WAIT_CYCLES wait states between
// accept and response (0 allowed), MEM_INIT optional hex image.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string MEM_INIT    = ""
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave dmem
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam int                CNT_W     = 16;
  localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0]  CNT_INIT  =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q, rdata_q, rdata_d;
  logic [2:0]       func3_q;
  logic             we_q, err_q, err_d;

  logic [31:0]      mem_q [DEPTH];

  logic             accept_s, eval_s, err_s, f3_err_s, range_err_s;
  logic [31:0]      cur_addr_s, cur_wdata_s, mem_rd_s;
  logic [2:0]       cur_func3_s;
  logic             cur_we_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [31:0]      lane_rdata_s, new_word_s;
  logic [3:0]       be_s;
  logic             misaligned_s;

  assign accept_s = dmem.req_valid && (state_q == IDLE);

  // With zero wait states the request is evaluated on its accept edge, so the
  // live inputs stand in for the not-yet-latched fields.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr_s  = dmem.req_addr;
      cur_we_s    = dmem.req_we;
      cur_func3_s = dmem.req_func3;
      cur_wdata_s = dmem.req_wdata;
    end else begin
      cur_addr_s  = addr_q;
      cur_we_s    = we_q;
      cur_func3_s = func3_q;
      cur_wdata_s = wdata_q;
    end
  end

  assign word_idx_s  = cur_addr_s[ADDR_WIDTH+1:2];
  assign mem_rd_s    = mem_q[word_idx_s];
  assign range_err_s = ((cur_addr_s >> (ADDR_WIDTH + 2)) != 32'd0);

  mem_lane_align u_align (
    .word_i       (mem_rd_s),
    .wdata_i      (cur_wdata_s),
    .offset_i     (cur_addr_s[1:0]),
    .func3_i      (cur_func3_s),
    .rdata_o      (lane_rdata_s),
    .new_word_o   (new_word_s),
    .be_o         (be_s),
    .misaligned_o (misaligned_s)
  );

  // Reserved funct3 codes, and unsigned variants that only exist for loads.
  always_comb begin
    case (cur_func3_s)
      3'b011, 3'b110, 3'b111: f3_err_s = 1'b1;
      F3_BU, F3_HU:           f3_err_s = cur_we_s;
      default:                f3_err_s = 1'b0;
    endcase
  end

  assign err_s = f3_err_s || misaligned_s || range_err_s;

  // FSM next state and wait-state counter; eval_s marks the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (ZERO_WAIT) begin
            state_d = RESP;
            eval_s  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = RESP;
          eval_s  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (dmem.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload captured once on evaluation, then held through RESP.
  always_comb begin
    if (eval_s) begin
      err_d   = err_s;
      rdata_d = (err_s || cur_we_s) ? 32'd0 : lane_rdata_s;
    end else begin
      err_d   = err_q;
      rdata_d = rdata_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request latch: fields are frozen at accept and ignore later input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      wdata_q <= 32'd0;
    end else if (accept_s) begin
      addr_q  <= dmem.req_addr;
      we_q    <= dmem.req_we;
      func3_q <= dmem.req_func3;
      wdata_q <= dmem.req_wdata;
    end
  end

  // Storage array (not reset); rst_n gating keeps a zero-wait store from
  // committing while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && eval_s && cur_we_s && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= new_word_s[8*i +: 8];
        end
      end
    end
  end

  assign dmem.req_ready = (state_q == IDLE);
  assign dmem.rsp_valid = (state_q == RESP);
  assign dmem.rsp_rdata = rdata_q;
  assign dmem.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (2 and 0 wait states), a
// byte-array reference model, per-instance expectation queues and monitors.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  req_valid_s, req_we_s, rsp_ready_s;
  logic [31:0] req_addr_s [2];
  logic [31:0] req_wdata_s [2];
  logic [2:0]  req_func3_s [2];
  logic [1:0]  req_ready_w, rsp_valid_w, rsp_err_w;
  logic [31:0] rsp_rdata_w [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [7:0] ref_mem [2][4096];

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t pop_exp(input int k);
    if (k == 0) return exp_q0.pop_front();
    else return exp_q1.pop_front();
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    if (k == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, RISC-V size/alignment/range rules.
  function automatic exp_t model(input int k, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int n;
    logic [31:0] v;
    e.err = 1'b0; e.rdata = 32'd0; e.due = 0; n = 1;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    e.err = 1'b1;
    endcase
    if (we && f3[2]) e.err = 1'b1;
    if ((addr % n) != 0) e.err = 1'b1;
    if (addr >= 32'h1000) e.err = 1'b1;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[k][int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[k][int'(addr) + i];
        if (!f3[2] && n < 4 && v[8*n-1]) begin
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // One transaction: wait for ready, present, accept, queue the expectation,
  // optionally stall the response bp cycles and keep a rogue request pending.
  task automatic issue(input int k, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [32:0] want, input int bp, input bit rogue,
                       output int acc_cyc);
    exp_t e;
    int t;
    t = 0;
    acc_cyc = -1;
    while (!req_ready_w[k] && t < 100) begin @(posedge clk); #1; t++; end
    if (!req_ready_w[k]) begin
      chk("req_ready_timeout", {31'd0, req_ready_w[k]}, 32'd1);
      return;
    end
    req_valid_s[k] = 1'b1; req_we_s[k] = we; req_func3_s[k] = f3;
    req_addr_s[k] = addr; req_wdata_s[k] = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    e = model(k, we, f3, addr, wd);
    if (want[32]) e.rdata = want[31:0];
    e.due = acc_cyc + wait_of(k);
    push_exp(k, e);
    if (rogue) begin
      req_we_s[k] = 1'b1; req_func3_s[k] = F3_W;
      req_addr_s[k] = 32'h40; req_wdata_s[k] = 32'hBAD0BAD0;
    end else begin
      req_valid_s[k] = 1'b0;
    end
    if (bp > 0) begin
      rsp_ready_s[k] = 1'b0;
      repeat (bp) begin @(posedge clk); #1; end
      rsp_ready_s[k] = 1'b1;
    end
    t = 0;
    while (qsize(k) != 0 && t < 200) begin @(posedge clk); #1; t++; end
    if (qsize(k) != 0) begin
      chk("rsp_timeout", 32'(qsize(k)), 32'd0);
      while (qsize(k) != 0) void'(pop_exp(k));
    end
    req_valid_s[k] = 1'b0;
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dmem_responder_if bus ();

    dmem_responder #(
      .ADDR_WIDTH  (10),
      .WAIT_CYCLES ((k == 0) ? 2 : 0),
      .MEM_INIT    ("")
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dmem  (bus)
    );

    assign bus.req_valid  = req_valid_s[k];
    assign bus.req_we     = req_we_s[k];
    assign bus.req_addr   = req_addr_s[k];
    assign bus.req_func3  = req_func3_s[k];
    assign bus.req_wdata  = req_wdata_s[k];
    assign bus.rsp_ready  = rsp_ready_s[k];
    assign req_ready_w[k] = bus.req_ready;
    assign rsp_valid_w[k] = bus.rsp_valid;
    assign rsp_err_w[k]   = bus.rsp_err;
    assign rsp_rdata_w[k] = bus.rsp_rdata;

    bit          seen = 1'b0;
    int          first_cyc;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;

    // Monitor: checks stability while stalled, then scores on handshake.
    always @(negedge clk) begin
      if (!rst_n) begin
        seen = 1'b0;
      end else if (rsp_valid_w[k]) begin
        chk("req_ready_during_resp", {31'd0, req_ready_w[k]}, 32'd0);
        if (!seen) begin
          seen = 1'b1; first_cyc = cyc;
          held_rdata = rsp_rdata_w[k]; held_err = rsp_err_w[k];
        end else begin
          chk("hold_rdata", rsp_rdata_w[k], held_rdata);
          chk("hold_err", {31'd0, rsp_err_w[k]}, {31'd0, held_err});
        end
        if (rsp_ready_s[k]) begin
          chk("rsp_expected", (qsize(k) > 0) ? 32'd1 : 32'd0, 32'd1);
          if (qsize(k) > 0) begin
            e = pop_exp(k);
            chk("rsp_rdata", rsp_rdata_w[k], e.rdata);
            chk("rsp_err", {31'd0, rsp_err_w[k]}, {31'd0, e.err});
            chk("rsp_latency", 32'(first_cyc), 32'(e.due));
          end
          seen = 1'b0;
        end
      end
    end
  end

  int a, prev;

  initial begin
    req_valid_s = 2'b00; req_we_s = 2'b00; rsp_ready_s = 2'b11;
    for (int k = 0; k < 2; k++) begin
      req_addr_s[k] = 32'd0; req_wdata_s[k] = 32'd0; req_func3_s[k] = 3'd0;
      for (int i = 0; i < 4096; i++) ref_mem[k][i] = 8'd0;
    end

    // Reset values, checked while reset is held.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", {31'd0, req_ready_w[k]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid_w[k]}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_w[k], 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err_w[k]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store/load (0x20 cleared for the reset test later).
    issue(0, 1'b1, F3_W, 32'h20, 32'h0, 33'h0, 0, 1'b0, a);
    issue(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 33'h1_00000000, 0, 1'b0, a);
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, 33'h1_DEADBEEF, 0, 1'b0, a);

    // Sub-word access.
    issue(0, 1'b1, F3_B, 32'h13, 32'h80, 33'h1_00000000, 0, 1'b0, a);
    issue(0, 1'b0, F3_B, 32'h13, 32'h0, 33'h1_FFFFFF80, 0, 1'b0, a);
    issue(0, 1'b0, F3_BU, 32'h13, 32'h0, 33'h1_00000080, 0, 1'b0, a);
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, 33'h1_80ADBEEF, 0, 1'b0, a);
    issue(0, 1'b0, F3_H, 32'h12, 32'h0, 33'h1_FFFF80AD, 0, 1'b0, a);

    // Misaligned store and out-of-range load.
    issue(0, 1'b1, F3_H, 32'h11, 32'h1234, 33'h1_00000000, 0, 1'b0, a);
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, 33'h1_80ADBEEF, 0, 1'b0, a);
    issue(0, 1'b0, F3_W, 32'h1000, 32'h0, 33'h1_00000000, 0, 1'b0, a);

    // Backpressure with a rogue store held on req_valid; it must not land.
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, 33'h1_80ADBEEF, 5, 1'b1, a);
    issue(0, 1'b0, F3_W, 32'h40, 32'h0, 33'h1_00000000, 0, 1'b0, a);

    // Reset while a store sits in BUSY: dropped, never committed.
    req_valid_s[0] = 1'b1; req_we_s[0] = 1'b1; req_func3_s[0] = F3_W;
    req_addr_s[0] = 32'h20; req_wdata_s[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid_s[0] = 1'b0;
    chk("busy_before_reset", {31'd0, req_ready_w[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_req_ready", {31'd0, req_ready_w[0]}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid_w[0]}, 32'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, F3_W, 32'h20, 32'h0, 33'h1_00000000, 0, 1'b0, a);

    // Zero wait states: back-to-back loads, one every 2 cycles.
    issue(1, 1'b1, F3_W, 32'h8, 32'hCAFEF00D, 33'h0, 0, 1'b0, a);
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      issue(1, 1'b0, (i % 2 == 0) ? F3_W : F3_H, 32'h8 + 32'(2 * (i % 2)),
            32'h0, 33'h0, 0, 1'b0, a);
      if (prev >= 0) chk("zero_wait_spacing", 32'(a - prev), 32'd2);
      prev = a;
    end

    // Randomized traffic on both instances against the reference model.
    for (int i = 0; i < 200; i++) begin
      int          k;
      logic [31:0] addr;
      k = $urandom_range(0, 1);
      addr = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                         : 32'($urandom_range(0, 255));
      issue(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
            33'h0, $urandom_range(0, 3), 1'b0, a);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
